fc_argmax_stream: RTL and testbench

//  Parametrised argmax classifier at the tail of the LeNet FC layer. Accepts the N_CLASS FC

---
 rtl/lenet_pkg.sv | 16 +
 rtl/fc_argmax_stream_if.sv | 26 ++
 rtl/argmax_lane_tree.sv | 44 ++++
 rtl/fc_argmax_stream.sv | 131 +++++++++++++
 tb/tb_fc_argmax_stream.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// lenet_pkg: shared defaults, sizing helpers and FSM state type for the LeNet FC tail
package lenet_pkg;
  localparam int DATA_SIZE = 8;
  localparam int N_CLASS_DEF = 10;
  localparam int LANES_DEF = 2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int beats(input int n, input int l);
    return (n + l - 1) / l;
  endfunction
  localparam int BEATS = beats(N_CLASS_DEF, LANES_DEF);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/fc_argmax_stream_if.sv
// fc_argmax_stream_if: score input stream plus held result port of the argmax classifier
// slave = classifier side, master = producer/consumer side
interface fc_argmax_stream_if #(
  parameter int DATA_W = 8,
  parameter int LANES = 2,
  parameter int IDX_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_last;
  logic                    res_valid;
  logic                    res_ready;
  logic [IDX_W-1:0]        res_idx;
  logic [DATA_W-1:0]       res_max;
  logic [DATA_W:0]         res_margin;
  logic                    res_err;
  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_idx, res_max, res_margin, res_err
  );
  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_idx, res_max, res_margin, res_err
  );
endinterface

// File: rtl/argmax_lane_tree.sv
// argmax_lane_tree: combinational top-2 of one beat's valid lanes, lowest index wins ties
// in: scores (LANES x DATA_W), lane_vld mask, base class index; out: best score/index, second score + valid
module argmax_lane_tree #(
  parameter int DATA_W = 8,
  parameter int LANES = 2,
  parameter int IDX_W = 8,
  parameter int SIGNED = 1
) (
  input  logic [LANES*DATA_W-1:0] scores,
  input  logic [LANES-1:0]        lane_vld,
  input  logic [IDX_W-1:0]        base,
  output logic [DATA_W-1:0]       best,
  output logic [IDX_W-1:0]        best_idx,
  output logic [DATA_W-1:0]       second,
  output logic                    second_vld
);
  // flipping the sign bit turns a two's-complement compare into an unsigned one
  localparam logic [DATA_W-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a ^ FLIP) > (b ^ FLIP);
  endfunction
  logic best_vld;
  always_comb begin
    best = '0;
    best_idx = '0;
    best_vld = 1'b0;
    second = '0;
    second_vld = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_vld[k]) begin
        if (!best_vld || gt(scores[k*DATA_W +: DATA_W], best)) begin
          second = best;
          second_vld = best_vld;
          best = scores[k*DATA_W +: DATA_W];
          best_idx = base + IDX_W'(k);
          best_vld = 1'b1;
        end else if (!second_vld || gt(scores[k*DATA_W +: DATA_W], second)) begin
          second = scores[k*DATA_W +: DATA_W];
          second_vld = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/fc_argmax_stream.sv
// fc_argmax_stream: streaming argmax over N_CLASS scores with top1-top2 margin and frame-length check
// clk/rst_n (async, active-low), flush (sync abort); s: input beats in_*, held result res_*
module fc_argmax_stream
  import lenet_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int N_CLASS = 10,
  parameter int LANES = 2,
  parameter int SIGNED = 1,
  parameter int IDX_W = 8
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  fc_argmax_stream_if.slave s
);
  localparam int N_BEATS = beats(N_CLASS, LANES);
  localparam int CNT_W = clog2(N_BEATS + 1);
  localparam logic [DATA_W-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
  if (LANES > N_CLASS || LANES < 1) begin : g_bad_lanes
    $error("fc_argmax_stream: LANES must be in 1..N_CLASS");
  end
  if (IDX_W < clog2(N_CLASS)) begin : g_bad_idx
    $error("fc_argmax_stream: IDX_W too small for N_CLASS");
  end
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a ^ FLIP) > (b ^ FLIP);
  endfunction
  function automatic logic [DATA_W:0] ext(input logic [DATA_W-1:0] x);
    return {(SIGNED != 0) & x[DATA_W-1], x};
  endfunction
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic in_ready_q, in_ready_d;
  logic [DATA_W-1:0] best_q, best_d, sec_q, sec_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic sv_q, sv_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [DATA_W-1:0] res_max_q, res_max_d;
  logic [DATA_W:0] res_margin_q, res_margin_d;
  logic res_err_q, res_err_d;
  logic [LANES-1:0] lane_vld;
  logic [IDX_W-1:0] base;
  logic [DATA_W-1:0] t_best, t_sec;
  logic [IDX_W-1:0] t_idx;
  logic t_sv, accept, first, last_beat, take, done;
  // lanes past the final class (padding in the last beat) are masked out
  always_comb begin
    lane_vld = '0;
    for (int k = 0; k < LANES; k++) lane_vld[k] = (int'(cnt_q) * LANES + k) < N_CLASS;
  end
  assign base = IDX_W'(int'(cnt_q) * LANES);
  argmax_lane_tree #(.DATA_W(DATA_W), .LANES(LANES), .IDX_W(IDX_W), .SIGNED(SIGNED)) u_tree (
    .scores(s.in_data), .lane_vld(lane_vld), .base(base),
    .best(t_best), .best_idx(t_idx), .second(t_sec), .second_vld(t_sv)
  );
  assign accept = s.in_valid & in_ready_q;
  assign first = state_q == IDLE;
  assign last_beat = cnt_q == CNT_W'(N_BEATS - 1);
  // running scores hold lower indices, so the new beat must be strictly greater to win
  assign take = first | gt(t_best, best_q);
  // a frame closes on in_last or on its nominal final beat, whichever comes first
  assign done = accept & (s.in_last | last_beat);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    best_d = best_q;
    idx_d = idx_q;
    sec_d = sec_q;
    sv_d = sv_q;
    res_idx_d = res_idx_q;
    res_max_d = res_max_q;
    res_margin_d = res_margin_q;
    res_err_d = res_err_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == DONE) begin
      state_d = s.res_ready ? IDLE : DONE;
    end else if (accept) begin
      best_d = take ? t_best : best_q;
      idx_d = take ? t_idx : idx_q;
      sec_d = first ? t_sec
            : take ? ((t_sv && gt(t_sec, best_q)) ? t_sec : best_q)
            : ((!sv_q || gt(t_best, sec_q)) ? t_best : sec_q);
      sv_d = first ? t_sv : 1'b1;
      cnt_d = done ? '0 : cnt_q + 1'b1;
      state_d = done ? DONE : ACC;
      if (done) begin
        res_idx_d = idx_d;
        res_max_d = best_d;
        res_margin_d = sv_d ? ext(best_d) - ext(sec_d) : '0;
        res_err_d = s.in_last ^ last_beat;
      end
    end
    in_ready_d = state_d != DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      in_ready_q <= 1'b0;
      best_q <= '0;
      idx_q <= '0;
      sec_q <= '0;
      sv_q <= 1'b0;
      res_idx_q <= '0;
      res_max_q <= '0;
      res_margin_q <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      in_ready_q <= in_ready_d;
      best_q <= best_d;
      idx_q <= idx_d;
      sec_q <= sec_d;
      sv_q <= sv_d;
      res_idx_q <= res_idx_d;
      res_max_q <= res_max_d;
      res_margin_q <= res_margin_d;
      res_err_q <= res_err_d;
    end
  end
  assign s.in_ready = in_ready_q;
  assign s.res_valid = state_q == DONE;
  assign s.res_idx = res_idx_q;
  assign s.res_max = res_max_q;
  assign s.res_margin = res_margin_q;
  assign s.res_err = res_err_q;
endmodule

// File: tb/tb_fc_argmax_stream.sv
// tb_fc_argmax_stream: directed frames into an unsigned/2-lane and a signed/3-lane classifier, scoreboard-checked results
module tb_fc_argmax_stream;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  always #5 clk = ~clk;
  fc_argmax_stream_if #(.DATA_W(8), .LANES(2), .IDX_W(8)) a ();
  fc_argmax_stream_if #(.DATA_W(8), .LANES(3), .IDX_W(8)) b ();
  fc_argmax_stream #(.DATA_W(8), .N_CLASS(10), .LANES(2), .SIGNED(0), .IDX_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s(a.slave));
  fc_argmax_stream #(.DATA_W(8), .N_CLASS(10), .LANES(3), .SIGNED(1), .IDX_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s(b.slave));
  typedef struct {
    logic [7:0] idx;
    logic [7:0] mx;
    logic [8:0] mg;
    logic       err;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [7:0] sc[12];
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic exp_a(input logic [7:0] i, input logic [7:0] m, input logic [8:0] g, input logic e);
    qa.push_back('{i, m, g, e});
  endtask
  task automatic exp_b(input logic [7:0] i, input logic [7:0] m, input logic [8:0] g, input logic e);
    qb.push_back('{i, m, g, e});
  endtask
  always @(negedge clk) begin
    if (rst_n && !flush && a.res_valid && a.res_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_result: got idx %0d with no expectation queued", a.res_idx);
      end else begin
        ea = qa.pop_front();
        chk("a_idx", a.res_idx, ea.idx);
        chk("a_max", a.res_max, ea.mx);
        chk("a_margin", a.res_margin, ea.mg);
        chk("a_err", a.res_err, ea.err);
      end
    end
    if (rst_n && !flush && b.res_valid && b.res_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_result: got idx %0d with no expectation queued", b.res_idx);
      end else begin
        eb = qb.pop_front();
        chk("b_idx", b.res_idx, eb.idx);
        chk("b_max", b.res_max, eb.mx);
        chk("b_margin", b.res_margin, eb.mg);
        chk("b_err", b.res_err, eb.err);
      end
    end
  end
  task automatic send_a(input logic [7:0] l0, input logic [7:0] l1, input logic last);
    bit acc = 0;
    int n = 0;
    a.in_valid = 1;
    a.in_data = {l1, l0};
    a.in_last = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = a.in_ready;
      @(posedge clk);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL a_accept_timeout: in_ready 0 required 1 within 50 cycles");
    end
    #1;
    a.in_valid = 0;
    a.in_last = 0;
  endtask
  task automatic send_b(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2, input logic last);
    bit acc = 0;
    int n = 0;
    b.in_valid = 1;
    b.in_data = {l2, l1, l0};
    b.in_last = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = b.in_ready;
      @(posedge clk);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL b_accept_timeout: in_ready 0 required 1 within 50 cycles");
    end
    #1;
    b.in_valid = 0;
    b.in_last = 0;
  endtask
  task automatic frame_a(input int nb, input bit last);
    for (int i = 0; i < nb; i++) send_a(sc[2*i], sc[2*i+1], last && i == nb - 1);
  endtask
  task automatic frame_b(input int nb, input bit last);
    for (int i = 0; i < nb; i++) send_b(sc[3*i], sc[3*i+1], sc[3*i+2], last && i == nb - 1);
  endtask
  task automatic chk_a_zero(input string tag);
    chk({tag, "_in_ready"}, a.in_ready, 0);
    chk({tag, "_res_valid"}, a.res_valid, 0);
    chk({tag, "_res_idx"}, a.res_idx, 0);
    chk({tag, "_res_max"}, a.res_max, 0);
    chk({tag, "_res_margin"}, a.res_margin, 0);
    chk({tag, "_res_err"}, a.res_err, 0);
  endtask
  task automatic release_reset(input string tag);
    @(posedge clk);
    #1 rst_n = 1;
    chk({tag, "_in_ready_before_clk"}, a.in_ready, 0);
    @(posedge clk);
    #1 chk({tag, "_in_ready_after_clk"}, a.in_ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    a.in_valid = 0; a.in_data = '0; a.in_last = 0; a.res_ready = 1;
    b.in_valid = 0; b.in_data = '0; b.in_last = 0; b.res_ready = 1;
    repeat (2) @(posedge clk);
    #1 chk_a_zero("reset");
    chk("reset_b_in_ready", b.in_ready, 0);
    release_reset("release");
    // unsigned tie at 9 -> lowest index 1, margin 0, result one clk after last beat
    sc = '{3, 9, 1, 9, 0, 2, 7, 4, 5, 8, 0, 0};
    exp_a(1, 9, 0, 0);
    frame_a(5, 1);
    chk("t1_res_valid_latency", a.res_valid, 1);
    chk("t1_in_ready_in_done", a.in_ready, 0);
    @(posedge clk);
    #1 chk("t1_in_ready_after_handshake", a.in_ready, 1);
    chk("t1_res_valid_dropped", a.res_valid, 0);
    // signed, padding lanes hold 127 and must be ignored
    sc = '{8'hFB, 8'hFE, 8'h80, 8'hFD, 8'hF7, 8'hFF, 8'hFC, 8'hF9, 8'hFA, 8'hF8, 8'h7F, 8'h7F};
    exp_b(5, 8'hFF, 1, 0);
    frame_b(4, 1);
    sc = '{8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    exp_b(0, 8'h7F, 255, 0);
    frame_b(4, 1);
    sc = '{8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'h7F, 8'h7F};
    exp_b(0, 8'hFD, 0, 0);
    frame_b(4, 1);
    sc = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h05, 8'h7F, 8'h7F};
    exp_b(9, 8'h05, 133, 0);
    frame_b(4, 1);
    // backpressure: result held 10 cycles, input blocked
    a.res_ready = 0;
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0};
    exp_a(9, 10, 1, 0);
    frame_a(5, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", a.res_valid, 1);
      chk("t3_hold_in_ready", a.in_ready, 0);
      chk("t3_hold_idx", a.res_idx, 9);
      chk("t3_hold_max", a.res_max, 10);
      chk("t3_hold_margin", a.res_margin, 1);
    end
    @(posedge clk);
    #1 a.res_ready = 1;
    @(posedge clk);
    #1 chk("t3_in_ready_after_handshake", a.in_ready, 1);
    sc = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    exp_a(0, 10, 1, 0);
    frame_a(5, 1);
    // early in_last on beat 3
    sc = '{4, 8, 6, 2, 1, 3, 0, 0, 0, 0, 0, 0};
    exp_a(1, 8, 2, 1);
    frame_a(3, 1);
    // missing in_last: forced DONE after beat 5, next beat opens a new frame
    sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0};
    exp_a(9, 9, 1, 1);
    frame_a(5, 0);
    chk("t4_forced_done", a.res_valid, 1);
    sc = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 0, 0};
    exp_a(0, 7, 0, 0);
    frame_a(5, 1);
    @(posedge clk);
    // flush mid-frame discards the partial frame
    sc = '{250, 250, 250, 250, 0, 0, 0, 0, 0, 0, 0, 0};
    #1 frame_a(2, 0);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("t5_flush_res_valid", a.res_valid, 0);
    sc = '{10, 20, 30, 40, 50, 60, 70, 200, 80, 90, 0, 0};
    exp_a(7, 200, 110, 0);
    frame_a(5, 1);
    @(posedge clk);
    // flush beats an input handshake in the same cycle
    #1 a.in_valid = 1;
    a.in_data = {8'd255, 8'd255};
    a.in_last = 0;
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    a.in_valid = 0;
    exp_a(7, 200, 110, 0);
    frame_a(5, 1);
    @(posedge clk);
    // flush drops a held result
    #1 a.res_ready = 0;
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0};
    frame_a(5, 1);
    chk("t5_done_before_flush", a.res_valid, 1);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("t5_flush_done_valid", a.res_valid, 0);
    chk("t5_flush_done_in_ready", a.in_ready, 1);
    a.res_ready = 1;
    // async reset during ACC
    sc = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    frame_a(2, 0);
    #2 rst_n = 0;
    #1 chk_a_zero("t6_acc");
    release_reset("t6_acc");
    // async reset during DONE
    a.res_ready = 0;
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0};
    frame_a(5, 1);
    chk("t6_done_before_reset", a.res_valid, 1);
    #2 rst_n = 0;
    #1 chk_a_zero("t6_done");
    release_reset("t6_done");
    a.res_ready = 1;
    sc = '{3, 9, 1, 9, 0, 2, 7, 4, 5, 8, 0, 0};
    exp_a(1, 9, 0, 0);
    frame_a(5, 1);
    repeat (3) @(posedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
